// File: rtl/mem_seq_pkg.sv
// Shared definitions for mem_access_sequencer: FSM state encoding, byte-lane
// selects and the word-to-byte address macro.
`ifndef MEM_SEQ_PKG_SV
`define MEM_SEQ_PKG_SV

`define MEM_SEQ_BYTE_ADDR(waddr, sel) {(waddr), (sel)}

package mem_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LO      = 3'd1,
    LO_WAIT = 3'd2,
    HI      = 3'd3,
    HI_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic LOW_BYTE  = 1'b0;
  localparam logic HIGH_BYTE = 1'b1;

endpackage

`endif

// File: rtl/mem_access_sequencer_if.sv
// Requester-side and memory-manager-side signals of mem_access_sequencer.
// master = the sequencer, slave = requesters plus memory manager.
interface mem_access_sequencer_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_SPACE = 23,
  parameter int WADDR_W    = 22
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*WADDR_W-1:0]    req_addr;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic [WORD_WIDTH-1:0]         rdata;
  logic                          busy;
  logic [ADDR_SPACE-1:0]         mm_address;
  logic                          mm_wren;
  logic [DATA_WIDTH-1:0]         mm_wdata;
  logic                          mm_data_oe;
  logic [DATA_WIDTH-1:0]         mm_rdata;

  modport master (
    input  req, req_we, req_addr, req_wdata, mm_rdata,
    output gnt, done, rdata, busy, mm_address, mm_wren, mm_wdata, mm_data_oe
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, mm_rdata,
    input  gnt, done, rdata, busy, mm_address, mm_wren, mm_wdata, mm_data_oe
  );
endinterface

// File: rtl/mem_access_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first request after pointer, with wrap.
// With MEM_SEQ_PRIORITY_EN defined, requester 0 wins outright and the rest rotate.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner
);

  logic found;
  int   cand;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    cand   = 0;
`ifdef MEM_SEQ_PRIORITY_EN
    if (req[0]) begin
      grant[0] = 1'b1;
      found    = 1'b1;
    end
    // Requester 0 is skipped in the rotation; it is served above.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(pointer) + k) % NUM_REQ;
      if (!found && cand != 0 && req[cand]) begin
        grant[cand] = 1'b1;
        winner      = cand[IDX_W-1:0];
        found       = 1'b1;
      end
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(pointer) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        winner      = cand[IDX_W-1:0];
        found       = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Serialises word requests from NUM_REQ requesters into low/high byte accesses on
// the memory manager host port. Optional macro: MEM_SEQ_PRIORITY_EN (see rr_arbiter).
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_SPACE = 23,
  parameter int WADDR_W    = 22,
  parameter int RD_LAT     = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  mem_access_sequencer_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 3;

  state_t                 state, state_d;
  logic [IDX_W-1:0]       ptr, idx_q, arb_idx;
  logic [NUM_REQ-1:0]     arb_gnt;
  logic                   we_q;
  logic [WADDR_W-1:0]     addr_q;
  logic [WORD_WIDTH-1:0]  wdata_q, rdata_q;
  logic [DATA_WIDTH-1:0]  lo_q;
  logic [CNT_W-1:0]       cnt;
  logic                   lat_done;

  logic [NUM_REQ-1:0]     gnt_c, done_c;
  logic [ADDR_SPACE-1:0]  addr_c;
  logic                   wren_c;
  logic [DATA_WIDTH-1:0]  wdata_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req     (bus.req),
    .pointer (ptr),
    .grant   (arb_gnt),
    .winner  (arb_idx)
  );

  assign lat_done = (cnt == CNT_W'(RD_LAT - 1));

  always_comb begin
    state_d = state;
    gnt_c   = '0;
    done_c  = '0;
    addr_c  = '0;
    wren_c  = 1'b0;
    wdata_c = '0;
    case (state)
      IDLE: begin
        // Grant is combinational in IDLE; rst_n keeps it quiet while reset is held.
        if (rst_n && |bus.req) begin
          gnt_c   = arb_gnt;
          state_d = LO;
        end
      end
      LO: begin
        addr_c  = `MEM_SEQ_BYTE_ADDR(addr_q, LOW_BYTE);
        wren_c  = we_q;
        if (we_q) wdata_c = wdata_q[DATA_WIDTH-1:0];
        state_d = we_q ? HI : LO_WAIT;
      end
      LO_WAIT: begin
        addr_c = `MEM_SEQ_BYTE_ADDR(addr_q, LOW_BYTE);
        if (lat_done) state_d = HI;
      end
      HI: begin
        addr_c  = `MEM_SEQ_BYTE_ADDR(addr_q, HIGH_BYTE);
        wren_c  = we_q;
        if (we_q) wdata_c = wdata_q[WORD_WIDTH-1:DATA_WIDTH];
        state_d = we_q ? RESP : HI_WAIT;
      end
      HI_WAIT: begin
        addr_c = `MEM_SEQ_BYTE_ADDR(addr_q, HIGH_BYTE);
        if (lat_done) state_d = RESP;
      end
      RESP: begin
        done_c[idx_q] = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= IDX_W'(NUM_REQ - 1);
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            idx_q   <= arb_idx;
            we_q    <= bus.req_we[arb_idx];
            addr_q  <= bus.req_addr[int'(arb_idx)*WADDR_W +: WADDR_W];
            wdata_q <= bus.req_wdata[int'(arb_idx)*WORD_WIDTH +: WORD_WIDTH];
`ifdef MEM_SEQ_PRIORITY_EN
            if (arb_idx != '0) ptr <= arb_idx;
`else
            ptr <= arb_idx;
`endif
          end
        end
        LO, HI: cnt <= '0;
        // Low byte is parked so rdata only changes when the whole word is ready.
        LO_WAIT: begin
          if (lat_done) lo_q <= bus.mm_rdata;
          else          cnt  <= cnt + CNT_W'(1);
        end
        HI_WAIT: begin
          if (lat_done) rdata_q <= {bus.mm_rdata, lo_q};
          else          cnt     <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt        = gnt_c;
  assign bus.done       = done_c;
  assign bus.rdata      = rdata_q;
  assign bus.busy       = (state != IDLE);
  assign bus.mm_address = addr_c;
  assign bus.mm_wren    = wren_c;
  assign bus.mm_data_oe = wren_c;
  assign bus.mm_wdata   = wdata_c;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: randomized requesters, a byte memory
// model with RD_LAT read latency, and a word-level reference of arbitration and timing.
`timescale 1ns/1ps
module tb_mem_access_sequencer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int WW = 16;
  localparam int AS = 23;
  localparam int WA = 22;
  localparam int RL = 2;
`ifdef MEM_SEQ_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  localparam int M_ONESHOT = 0;
  localparam int M_HOLD    = 1;
  localparam int M_RAND    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_sequencer_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .WORD_WIDTH(WW),
                            .ADDR_SPACE(AS), .WADDR_W(WA)) bus ();

  mem_access_sequencer #(.NUM_REQ(N), .DATA_WIDTH(DW), .WORD_WIDTH(WW),
                         .ADDR_SPACE(AS), .WADDR_W(WA), .RD_LAT(RL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int            idx;
    bit            we;
    logic [WA-1:0] a;
    logic [WW-1:0] wd;
    logic [WW-1:0] rd;
    int            gcyc;
    int            lat;
  } txn_t;

  txn_t          sb[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_gnt = 0;
  int            free_at = 0;
  int            mode = M_ONESHOT;
  bit            finish_req = 1'b0;
  logic [N-1:0]  gnt_seen = '0;
  logic [7:0]    mm_mem  [logic [AS-1:0]];
  logic [7:0]    ref_mem [logic [AS-1:0]];
  logic [DW-1:0] rd_pipe [RL];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] dflt(input logic [AS-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hC3;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [AS-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Spec rule: first requester after the pointer, with wrap; optional fixed priority for 0.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    if (PRIO && r[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j] && !(PRIO && j == 0)) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory manager model: byte array with a registered RD_LAT-deep read pipeline.
  assign bus.mm_rdata = rd_pipe[RL-1];
  initial begin
    logic [AS-1:0] a_s;
    logic          w_s;
    logic [DW-1:0] wd_s;
    for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
    mm_mem[23'h000020] = 8'h34;
    mm_mem[23'h000021] = 8'h12;
    forever begin
      @(negedge clk);
      a_s = bus.mm_address; w_s = bus.mm_wren; wd_s = bus.mm_wdata;
      @(posedge clk);
      for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0] <= mm_mem.exists(a_s) ? mm_mem[a_s] : dflt(a_s);
      if (w_s) mm_mem[a_s] = wd_s;
    end
  end

  // Monitor / scoreboard
  initial begin
    txn_t          t, cur;
    bit            cur_v;
    int            ref_ptr, off, w;
    logic [N-1:0]  exp_g, exp_d;
    logic [AS-1:0] e_addr;
    logic          e_wren, e_busy;
    logic [DW-1:0] e_wd;
    cur_v = 1'b0; ref_ptr = N - 1;
    ref_mem[23'h000020] = 8'h34;
    ref_mem[23'h000021] = 8'h12;
    forever begin
      @(negedge clk);
      if (finish_req) begin
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
      if (!rst_n) begin
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_mm_address", bus.mm_address, 0);
        chk("rst_mm_wren", bus.mm_wren, 0);
        chk("rst_mm_oe", bus.mm_data_oe, 0);
        chk("rst_mm_wdata", bus.mm_wdata, 0);
        sb.delete(); cur_v = 1'b0; ref_ptr = N - 1; free_at = 0;
      end else begin
        e_addr = '0; e_wren = 1'b0; e_wd = '0; e_busy = 1'b0;
        if (cur_v) begin
          off = cyc - cur.gcyc;
          e_busy = (off >= 1 && off <= cur.lat);
          if (cur.we) begin
            if (off == 1) begin e_addr = {cur.a, 1'b0}; e_wren = 1'b1; e_wd = cur.wd[7:0]; end
            if (off == 2) begin e_addr = {cur.a, 1'b1}; e_wren = 1'b1; e_wd = cur.wd[15:8]; end
          end else begin
            if (off >= 1 && off <= 1 + RL)          e_addr = {cur.a, 1'b0};
            if (off >= 2 + RL && off <= 2 + 2 * RL) e_addr = {cur.a, 1'b1};
          end
        end
        chk("busy", bus.busy, e_busy);
        chk("mm_address", bus.mm_address, e_addr);
        chk("mm_wren", bus.mm_wren, e_wren);
        chk("mm_data_oe", bus.mm_data_oe, e_wren);
        chk("mm_wdata", bus.mm_wdata, e_wd);

        if (bus.done != '0) begin
          if (sb.size() == 0) chk("done_unexpected", bus.done, 0);
          else begin
            t = sb.pop_front();
            exp_d = '0; exp_d[t.idx] = 1'b1;
            chk("done_idx", bus.done, exp_d);
            chk("done_cycle", cyc, t.gcyc + t.lat);
            if (!t.we) chk("rdata", bus.rdata, t.rd);
          end
        end
        if (sb.size() > 0 && cyc > sb[0].gcyc + sb[0].lat) begin
          n_cmp++; n_bad++;
          $display("FAIL done_timeout: requester %0d granted at cycle %0d never completed", sb[0].idx, sb[0].gcyc);
          void'(sb.pop_front());
        end

        exp_g = '0; w = -1;
        if (cyc >= free_at && bus.req != '0) begin
          w = rr_pick(bus.req, ref_ptr);
          exp_g[w] = 1'b1;
        end
        if (bus.gnt != '0 || exp_g != '0) chk("gnt", bus.gnt, exp_g);
        if (w >= 0) begin
          t.idx  = w;
          t.we   = bus.req_we[w];
          t.a    = bus.req_addr[w*WA +: WA];
          t.wd   = bus.req_wdata[w*WW +: WW];
          t.gcyc = cyc;
          t.lat  = t.we ? 3 : 3 + 2 * RL;
          t.rd   = {ref_rd({t.a, 1'b1}), ref_rd({t.a, 1'b0})};
          if (t.we) begin
            ref_mem[{t.a, 1'b0}] = t.wd[7:0];
            ref_mem[{t.a, 1'b1}] = t.wd[15:8];
          end
          sb.push_back(t);
          cur = t; cur_v = 1'b1;
          free_at = cyc + t.lat + 1;
          n_gnt++;
          if (!(PRIO && w == 0)) ref_ptr = w;
        end
      end
      gnt_seen = rst_n ? bus.gnt : '0;
    end
  end

  // Driver
  function automatic logic [WA-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return '1;
    return WA'($urandom_range(0, 7));
  endfunction

  task automatic set_fields(input int i);
    bus.req_we[i]              = 1'($urandom_range(0, 1));
    bus.req_addr[i*WA +: WA]   = rand_addr();
    bus.req_wdata[i*WW +: WW]  = WW'($urandom);
  endtask

  task automatic issue(input int i, input bit we, input logic [WA-1:0] a, input logic [WW-1:0] d);
    bus.req_we[i]             = we;
    bus.req_addr[i*WA +: WA]  = a;
    bus.req_wdata[i*WW +: WW] = d;
    bus.req[i]                = 1'b1;
  endtask

  // After a grant the requester scrambles its inputs, which the DUT must ignore.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (gnt_seen[i]) begin
        set_fields(i);
        if (mode == M_ONESHOT)   bus.req[i] = 1'b0;
        else if (mode == M_RAND) bus.req[i] = 1'($urandom_range(0, 1));
      end else if (mode == M_RAND) begin
        if (!bus.req[i]) begin
          if ($urandom_range(0, 3) == 0) begin set_fields(i); bus.req[i] = 1'b1; end
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.req != '0 || cyc < free_at || bus.busy) && n < 300) begin
      cycle();
      n++;
    end
    if (n >= 300) begin
      $display("FAIL wait_idle: sequencer did not drain, req=%b busy=%b", bus.req, bus.busy);
      $fatal(1, "driver stalled");
    end
    cycle();
  endtask

  initial begin
    int start, k;
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    rst_n = 1'b0;
    bus.req[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.req = '0;
    #2 rst_n = 1'b1;

    issue(1, 1'b1, 22'h000123, 16'hBEEF); wait_idle();
    issue(0, 1'b0, 22'h000010, 16'h0000); wait_idle();
    issue(0, 1'b0, 22'h000123, 16'h0000); wait_idle();

    for (int i = 0; i < N; i++) set_fields(i);
    mode = M_HOLD; bus.req = '1;
    repeat (40) cycle();
    mode = M_ONESHOT; wait_idle();

    issue(0, 1'b0, 22'h000005, 16'h0000);
    start = n_gnt; k = 0;
    while (n_gnt == start && k < 20) begin cycle(); k++; end
    if (k >= 20) begin
      $display("FAIL reset_test: no grant for requester 0");
      $fatal(1, "driver stalled");
    end
    cycle();
    #1 rst_n = 1'b0;
    bus.req = '0;
    issue(2, 1'b1, 22'h000004, 16'h7E81);
    cycle(); cycle();
    #2 rst_n = 1'b1;
    wait_idle();
    issue(1, 1'b0, 22'h000004, 16'h0000); wait_idle();

    issue(2, 1'b1, 22'h3FFFFF, 16'h55AA); wait_idle();
    issue(1, 1'b0, 22'h3FFFFF, 16'h0000); wait_idle();

    issue(3, 1'b1, 22'h000007, 16'hA5C3); wait_idle();
    issue(3, 1'b0, 22'h000007, 16'h0000); wait_idle();

    mode = M_RAND;
    repeat (600) cycle();
    mode = M_ONESHOT;
    bus.req = '0;
    wait_idle();

    finish_req = 1'b1;
  end

endmodule
